// File: rtl/if_instruction_loader.sv
// -----------------------------------------------------------------------------
// if_instruction_loader
//
// Packs a big-endian byte stream into 32-bit words and writes them to an
// instruction memory. A start pulse begins a new image. Bytes are accepted in
// LOAD. After the fourth byte of a word, or the byte flagged last, the loader
// spends one WRITE cycle with mem_we high. The image finishes in DONE on the
// last word, or in ERR if the image is longer than DEPTH words.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid=1 and
// byte_ready=1. byte_ready is high only in LOAD and does not depend on
// byte_valid. The source may hold or drop byte_valid freely.
//
// Ports
//   clk         in   clock; all state updates on the rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle pulse: begin a load (ignored in LOAD/WRITE)
//   byte_valid  in   byte_data is valid
//   byte_data   in   [7:0] image byte, most significant byte of each word first
//   byte_last   in   final byte of the image (qualified by byte_valid)
//   byte_ready  out  loader accepts a byte this cycle (LOAD only)
//   mem_we      out  one-cycle word write strobe (WRITE only)
//   mem_addr    out  [ADDR_W-1:0] word address, registered
//   mem_wdata   out  [31:0] word data, registered
//   busy        out  high in LOAD and WRITE
//   done        out  sticky: image loaded
//   error       out  sticky: image overflowed DEPTH words
//   word_count  out  [ADDR_W:0] words written since the last start
//   dbg_state   out  [2:0] FSM state (0 IDLE, 1 LOAD, 2 WRITE, 3 DONE, 4 ERR)
// -----------------------------------------------------------------------------
module if_instruction_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic [1:0]          r_lane;
  logic [31:0]         r_word;
  logic                r_last;
  logic [ADDR_W:0]     r_word_count;
  logic                r_byte_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic                w_accept;
  logic                w_full;
  logic [31:0]         w_merged;

  // r_byte_ready mirrors "state is LOAD", so this is the transfer condition.
  assign w_accept = r_byte_ready && byte_valid;
  assign w_full   = (r_word_count == C_DEPTH);

  // Current partial word with the incoming byte dropped into its lane. Lower
  // lanes are still zero because r_word is cleared at every word boundary,
  // which provides the zero padding of a short final word.
  always_comb begin
    w_merged = r_word;
    case (r_lane)
      2'd0:    w_merged[31:24] = byte_data;
      2'd1:    w_merged[23:16] = byte_data;
      2'd2:    w_merged[15:8]  = byte_data;
      default: w_merged[7:0]   = byte_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lane       <= 2'd0;
      r_word       <= 32'd0;
      r_last       <= 1'b0;
      r_word_count <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state      <= S_LOAD;
            r_lane       <= 2'd0;
            r_word       <= 32'd0;
            r_last       <= 1'b0;
            r_word_count <= '0;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            if (w_full) begin
              // Memory already holds DEPTH words: this byte has no home.
              r_state      <= S_ERR;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_error      <= 1'b1;
            end else if ((r_lane == 2'd3) || byte_last) begin
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_word_count[ADDR_W-1:0];
              r_mem_wdata  <= w_merged;
              r_last       <= byte_last;
              r_lane       <= 2'd0;
              r_word       <= 32'd0;
            end else begin
              r_lane <= r_lane + 2'd1;
              r_word <= w_merged;
            end
          end
        end

        S_WRITE: begin
          r_mem_we     <= 1'b0;
          r_word_count <= r_word_count + C_ONE;
          if (r_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state      <= S_LOAD;
            r_byte_ready <= 1'b1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_mem_we     <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_if_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_if_instruction_loader
//
// Bench for if_instruction_loader with a 4-word memory (DEPTH=4, ADDR_W=2).
// Whole-image vectors come from a table. Hand-written sequences cover reset
// in mid-word, reset during a pending write, and start pulses in LOAD and
// DONE. Expected {addr, data} writes are queued as bytes are driven and are
// popped by a monitor whenever mem_we is seen.
// -----------------------------------------------------------------------------
module tb_if_instruction_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_last;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;
  logic [2:0]        dbg_state;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic               prev_we;

  typedef struct packed {
    logic [4:0]       len;
    logic             gap;
    logic [16:0][7:0] bytes;
    logic             exp_done;
    logic             exp_err;
    logic [2:0]       exp_wc;
  } vec_t;

  vec_t vecs[7];

  if_instruction_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we must match the head of the expected queue and
  // last exactly one cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we <= 1'b0;
    end else begin
      if (mem_we) begin
        check("we_pulse_width", 64'(prev_we), 64'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
        end else begin
          check("write_addr_data", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
        end
      end
      prev_we <= mem_we;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge. Holds the byte until the loader is ready, then
  // returns at the negedge following the accepting edge.
  task automatic push_byte(input logic [7:0] b, input logic last, input logic gap,
                           input bit completes, input bit ovf);
    int waited;
    waited = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    while (!byte_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      if (completes) check("we_latency", 64'(mem_we), 64'd1);
      if (ovf) begin
        check("ovf_error", 64'(error), 64'd1);
        check("ovf_no_we", 64'(mem_we), 64'd0);
      end
      if (gap) @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] acc;
    int          lane;
    int          wc;
    int          w;
    bit          completes;
    bit          ovf;
    logic        lastb;
    acc  = 32'd0;
    lane = 0;
    wc   = 0;
    ovf  = 1'b0;
    do_start();
    check($sformatf("v%0d_start_wc", idx), 64'(word_count), 64'd0);
    check($sformatf("v%0d_start_flags", idx), 64'({busy, done, error, byte_ready}), 64'b1001);
    for (int k = 0; k < int'(v.len); k++) begin
      lastb     = (k == int'(v.len) - 1);
      completes = 1'b0;
      if (wc == DEPTH) begin
        ovf = 1'b1;
      end else begin
        acc = acc | (32'(v.bytes[k]) << (8 * (3 - lane)));
        if (lane == 3 || lastb) begin
          exp_q.push_back({ADDR_W'(wc), acc});
          completes = 1'b1;
          acc  = 32'd0;
          lane = 0;
          wc++;
        end else begin
          lane++;
        end
      end
      push_byte(v.bytes[k], lastb, v.gap, completes, ovf);
      if (ovf) break;
    end
    w = 0;
    while (!(done || error) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("v%0d_done", idx), 64'(done), 64'(v.exp_done));
    check($sformatf("v%0d_error", idx), 64'(error), 64'(v.exp_err));
    check($sformatf("v%0d_word_count", idx), 64'(word_count), 64'(v.exp_wc));
    check($sformatf("v%0d_idle_outs", idx), 64'({busy, byte_ready, mem_we}), 64'd0);
    check($sformatf("v%0d_state", idx), 64'(dbg_state), v.exp_err ? 64'(ST_ERR) : 64'(ST_DONE));
    check($sformatf("v%0d_writes_seen", idx), 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    check({tag, "_flags"}, 64'({byte_ready, mem_we, busy, done, error}), 64'd0);
    check({tag, "_addr_data"}, 64'({mem_addr, mem_wdata}), 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    // Vector table: inputs (bytes, length, gaps) and expected final status.
    for (int i = 0; i < 7; i++) vecs[i] = '0;
    vecs[0].len = 5'd8; vecs[0].exp_done = 1'b1; vecs[0].exp_wc = 3'd2;
    vecs[0].bytes[0] = 8'h8C; vecs[0].bytes[1] = 8'h01; vecs[0].bytes[2] = 8'h00; vecs[0].bytes[3] = 8'h04;
    vecs[0].bytes[4] = 8'h20; vecs[0].bytes[5] = 8'h42; vecs[0].bytes[6] = 8'h00; vecs[0].bytes[7] = 8'h01;
    vecs[1].len = 5'd2; vecs[1].exp_done = 1'b1; vecs[1].exp_wc = 3'd1;
    vecs[1].bytes[0] = 8'hAA; vecs[1].bytes[1] = 8'hBB;
    vecs[2] = vecs[0];
    vecs[2].gap = 1'b1;
    vecs[3].len = 5'd16; vecs[3].exp_done = 1'b1; vecs[3].exp_wc = 3'd4;
    for (int k = 0; k < 16; k++) vecs[3].bytes[k] = 8'(k * 17 + 3);
    vecs[4].len = 5'd17; vecs[4].exp_err = 1'b1; vecs[4].exp_wc = 3'd4;
    for (int k = 0; k < 17; k++) vecs[4].bytes[k] = 8'(255 - k * 9);
    vecs[5].len = 5'd5; vecs[5].exp_done = 1'b1; vecs[5].exp_wc = 3'd2;
    vecs[5].bytes[0] = 8'h11; vecs[5].bytes[1] = 8'h22; vecs[5].bytes[2] = 8'h33;
    vecs[5].bytes[3] = 8'h44; vecs[5].bytes[4] = 8'h55;
    vecs[6].len = 5'd3; vecs[6].gap = 1'b1; vecs[6].exp_done = 1'b1; vecs[6].exp_wc = 3'd1;
    for (int k = 0; k < 3; k++) vecs[6].bytes[k] = 8'($urandom_range(1, 255));

    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Stays idle without start even with bytes offered.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) @(negedge clk);
    check("idle_no_ready", 64'({byte_ready, busy}), 64'd0);
    check("idle_state", 64'(dbg_state), 64'(ST_IDLE));
    byte_valid = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset mid-word after two bytes: immediate IDLE, everything cleared.
    do_start();
    push_byte(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midword_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midword_rst_stay_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Reset just after the completing byte is taken: the write is dropped.
    do_start();
    push_byte(8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'hC2, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'hC4;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("write_rst_we", 64'(mem_we), 64'd0);
    check("write_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("write_rst_no_count", 64'(word_count), 64'd0);

    // Start during LOAD is ignored: the lane position survives.
    do_start();
    exp_q.push_back({ADDR_W'(0), 32'hAABBCCDD});
    push_byte(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_start_state", 64'(dbg_state), 64'(ST_LOAD));
    check("load_start_wc", 64'(word_count), 64'd0);
    push_byte(8'hCC, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'hDD, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("load_start_done", 64'({done, word_count}), {60'd0, 1'b1, 3'd1});
    check("load_start_writes_seen", 64'(exp_q.size()), 64'd0);

    // Start in DONE restarts a load and clears the status.
    do_start();
    check("done_start_state", 64'(dbg_state), 64'(ST_LOAD));
    check("done_start_clear", 64'({done, error, word_count}), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_instruction_loader.md
IF_INSTRUCTION_LOADER -- requirements
Module: if_instruction_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the instruction-memory depth in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the word-address width, with 2^ADDR_W = DEPTH.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: single-cycle pulse that begins a new image load.
REQ-006 Port byte_valid, input, 1: byte_data holds a valid image byte.
REQ-007 Port byte_data, input, 8: image byte stream, most significant byte of each word first.
REQ-008 Port byte_last, input, 1: qualifies the final byte of the image; meaningful only with byte_valid.
REQ-009 Port byte_ready, output, 1: the loader accepts byte_data this cycle.
REQ-010 Port mem_we, output, 1: instruction-memory word write strobe.
REQ-011 Port mem_addr, output, ADDR_W: word address for the write.
REQ-012 Port mem_wdata, output, 32: word to write.
REQ-013 Port busy, output, 1: high in LOAD and WRITE.
REQ-014 Port done, output, 1: image loaded successfully; sticky.
REQ-015 Port error, output, 1: image overflowed DEPTH; sticky.
REQ-016 Port word_count, output, ADDR_W+1: number of words written since the last start.

Function
REQ-017 The states SHALL be IDLE, LOAD, WRITE, DONE, and ERR.
REQ-018 A byte SHALL transfer only on a cycle with byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 only in LOAD.
REQ-020 Transition IDLE/DONE/ERR -> LOAD on start=1: clear the byte lane counter, word_count, done, and error.
REQ-021 start SHALL be ignored in LOAD and WRITE.
REQ-022 Byte packing SHALL be big-endian: lane 0 -> [31:24], lane 1 -> [23:16], lane 2 -> [15:8], lane 3 -> [7:0].
REQ-023 The lane counter SHALL advance per accepted byte and wrap from 3 to 0.
REQ-024 LOAD -> WRITE SHALL occur when an accepted byte is in lane 3, or when it carries byte_last.
REQ-025 When byte_last arrives in lane 0-2, the unfilled lower lanes SHALL be zero-padded.
REQ-026 In WRITE, mem_we SHALL be 1 for exactly that one cycle.
REQ-027 In WRITE, mem_addr SHALL equal word_count[ADDR_W-1:0] and mem_wdata SHALL equal the assembled word.
REQ-028 Write latency SHALL be: completing byte accepted at cycle N -> mem_we=1 at cycle N+1.
REQ-029 word_count SHALL increment at the end of the WRITE cycle.
REQ-030 WRITE -> DONE SHALL occur if the word was flagged last; otherwise WRITE -> LOAD.
REQ-031 The maximum sustained rate SHALL be 4 bytes per 5 cycles.
REQ-032 In LOAD with word_count = DEPTH, an accepted byte SHALL cause LOAD -> ERR; nothing is written and error=1.
REQ-033 A final word landing exactly at address DEPTH-1 SHALL be legal and end in DONE with word_count = DEPTH.
REQ-034 In DONE, done SHALL be 1; in ERR, error SHALL be 1; both SHALL hold until the next start or reset.
REQ-035 mem_we SHALL be 0 in every state other than WRITE.
REQ-036 mem_addr and mem_wdata SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-037 rst_n=0 SHALL force IDLE immediately, independent of clk.
REQ-038 rst_n=0 SHALL set byte_ready, mem_we, busy, done, and error to 0.
REQ-039 rst_n=0 SHALL set mem_addr, mem_wdata, word_count, and the lane counter to 0.
REQ-040 Reset asserted in LOAD or WRITE SHALL abort the load: a pending mem_we is dropped, and no write occurs after release.
REQ-041 After reset release, the block SHALL stay in IDLE until start.

Verification
REQ-042 Scenario: start, then bytes 8C 01 00 04, 20 42 00 01 (last on 01) -> writes addr 0 = 8C010004 and addr 1 = 20420001; done=1; word_count=2.
REQ-043 Scenario: start, then bytes AA BB with last on BB -> one write, addr 0 = AABB0000; done=1.
REQ-044 Scenario: byte_valid toggling 1,0,1,0 between bytes -> the same words as REQ-042, and mem_we exactly one cycle per word.
REQ-045 Scenario: with DEPTH=4, stream 17 bytes -> 4 writes at addr 0-3, then error=1 on the 17th byte and no 5th write.
REQ-046 Scenario: rst_n pulsed low mid-word after 2 bytes -> immediate IDLE, all outputs 0, no write ever seen.
REQ-047 Scenario: start pulsed during LOAD -> ignored, counters unchanged; start in DONE -> word_count=0, done=0, state LOAD.
